// File: rtl/opendap_apb4_async_bridge.sv
// opendap_apb4_async_bridge
// APB4-to-APB4 clock-domain crossing for the bottom side of the Mem-AP.
// The transport side (clk_src) launches one access at a time through a level
// req/ack four-phase handshake into the target bus side (clk_dst). A src-side
// timeout answers with PSLVERR when clk_dst is stopped or held in reset; the
// abandoned request is then drained before new traffic is accepted.

// Multi-flop synchroniser for one level signal.
module opendap_sync_1bit #(
   parameter int unsigned N_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [N_STAGES-1:0] sync_q;

   // Shift the asynchronous level through the flop chain.
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would collapse
   // the chain into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < int'(N_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[N_STAGES-1];

endmodule

module opendap_apb4_async_bridge #(
   parameter int unsigned W_ADDR         = 8,
   parameter int unsigned W_DATA         = 32,
   parameter int unsigned N_SYNC_STAGES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                clk_src,
   input  logic                rst_n_src,
   input  logic                clk_dst,
   input  logic                rst_n_dst,
   // src side: APB4 slave
   input  logic                src_psel,
   input  logic                src_penable,
   input  logic                src_pwrite,
   input  logic [W_ADDR-1:0]   src_paddr,
   input  logic [W_DATA-1:0]   src_pwdata,
   input  logic [W_DATA/8-1:0] src_pstrb,
   input  logic [2:0]          src_pprot,
   output logic [W_DATA-1:0]   src_prdata,
   output logic                src_pready,
   output logic                src_pslverr,
   output logic                src_timeout_flag,
   input  logic                src_timeout_clr,
   output logic                src_draining,
   // dst side: APB4 master
   output logic                dst_psel,
   output logic                dst_penable,
   output logic                dst_pwrite,
   output logic [W_ADDR-1:0]   dst_paddr,
   output logic [W_DATA-1:0]   dst_pwdata,
   output logic [W_DATA/8-1:0] dst_pstrb,
   output logic [2:0]          dst_pprot,
   input  logic [W_DATA-1:0]   dst_prdata,
   input  logic                dst_pready,
   input  logic                dst_pslverr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ACKW,
      S_DRAIN_REQ,
      S_DRAIN_ACK
   } src_state_e;

   // ------------------------------------------------------------------ src
   src_state_e          state_q, state_d;
   logic                req_q, req_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;
   logic [W_DATA-1:0]   prdata_q, prdata_d;
   logic                flag_q, flag_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                load_l;
   logic                ack_s;
   logic                setup;
   logic                timeout_hit;

   // Launch register: read by clk_dst only while req holds it frozen.
   logic                l_pwrite_q;
   logic [W_ADDR-1:0]   l_paddr_q;
   logic [W_DATA-1:0]   l_pwdata_q;
   logic [W_DATA/8-1:0] l_pstrb_q;
   logic [2:0]          l_pprot_q;

   // ------------------------------------------------------------------ dst
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                ack_q, ack_d;
   logic                req_s;
   logic                cap;

   logic                c_pwrite_q;
   logic [W_ADDR-1:0]   c_paddr_q;
   logic [W_DATA-1:0]   c_pwdata_q;
   logic [W_DATA/8-1:0] c_pstrb_q;
   logic [2:0]          c_pprot_q;

   // Response register: read by clk_src only after ack has fallen.
   logic [W_DATA-1:0]   r_prdata_q;
   logic                r_pslverr_q;

   opendap_sync_1bit #(.N_STAGES(N_SYNC_STAGES)) u_sync_req (
      .clk   (clk_dst),
      .rst_n (rst_n_dst),
      .d_i   (req_q),
      .q_o   (req_s)
   );

   opendap_sync_1bit #(.N_STAGES(N_SYNC_STAGES)) u_sync_ack (
      .clk   (clk_src),
      .rst_n (rst_n_src),
      .d_i   (ack_q),
      .q_o   (ack_s)
   );

   assign setup       = src_psel && !src_penable;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   // src FSM next-state and response logic; normal exits are tested before the timeout.
   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      cnt_d     = cnt_q;
      flag_d    = src_timeout_clr ? 1'b0 : flag_q;
      load_l    = 1'b0;

      if ((state_q == S_REQ || state_q == S_ACKW) && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (setup) begin
               load_l   = 1'b1;
               req_d    = 1'b1;
               pready_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = S_ACKW;
            end else if (timeout_hit) begin
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
               flag_d    = 1'b1;
               state_d   = S_DRAIN_REQ;
            end
         end
         S_ACKW: begin
            if (!ack_s) begin
               pready_d  = 1'b1;
               prdata_d  = r_prdata_q;
               pslverr_d = r_pslverr_q;
               state_d   = S_IDLE;
            end else if (timeout_hit) begin
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
               flag_d    = 1'b1;
               state_d   = S_DRAIN_ACK;
            end
         end
         S_DRAIN_REQ: begin
            if (setup) begin
               pslverr_d = 1'b1;
               prdata_d  = '0;
            end
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = S_DRAIN_ACK;
            end
         end
         S_DRAIN_ACK: begin
            if (setup) begin
               pslverr_d = 1'b1;
               prdata_d  = '0;
            end
            if (!ack_s) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // src control and response state.
   always_ff @(posedge clk_src or negedge rst_n_src) begin
      if (!rst_n_src) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         pready_q  <= 1'b1;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         flag_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         flag_q    <= flag_d;
         cnt_q     <= cnt_d;
      end
   end

   // Launch register capture on acceptance in IDLE.
   // NOTE: data-path registers carry no reset; they are only consumed after a
   // handshake has qualified them, so resetting them would buy nothing.
   always_ff @(posedge clk_src) begin
      if (load_l) begin
         l_pwrite_q <= src_pwrite;
         l_paddr_q  <= src_paddr;
         l_pwdata_q <= src_pwdata;
         l_pstrb_q  <= src_pstrb;
         l_pprot_q  <= src_pprot;
      end
   end

   // dst handshake and APB sequencing: ack rises with the launch, falls once req is gone and the bus is idle.
   always_comb begin
      psel_d    = psel_q;
      penable_d = penable_q;
      ack_d     = ack_q;
      cap       = 1'b0;

      if (req_s && !ack_q) begin
         ack_d  = 1'b1;
         psel_d = 1'b1;
         cap    = 1'b1;
      end
      if (psel_q && !penable_q) begin
         penable_d = 1'b1;
      end
      if (psel_q && penable_q && dst_pready) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
      end
      if (!req_s && ack_q && !psel_q) begin
         ack_d = 1'b0;
      end
   end

   // dst control state.
   always_ff @(posedge clk_dst or negedge rst_n_dst) begin
      if (!rst_n_dst) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         psel_q    <= psel_d;
         penable_q <= penable_d;
         ack_q     <= ack_d;
      end
   end

   // Cross-domain capture of the launch register while req holds it stable.
   always_ff @(posedge clk_dst) begin
      if (cap) begin
         c_pwrite_q <= l_pwrite_q;
         c_paddr_q  <= l_paddr_q;
         c_pwdata_q <= l_pwdata_q;
         c_pstrb_q  <= l_pstrb_q;
         c_pprot_q  <= l_pprot_q;
      end
   end

   // Response capture on dst completion.
   always_ff @(posedge clk_dst) begin
      if (penable_q && dst_pready) begin
         r_prdata_q  <= dst_prdata;
         r_pslverr_q <= dst_pslverr;
      end
   end

   assign src_prdata       = prdata_q;
   assign src_pready       = pready_q;
   assign src_pslverr      = pslverr_q;
   assign src_timeout_flag = flag_q;
   assign src_draining     = (state_q == S_DRAIN_REQ) || (state_q == S_DRAIN_ACK);

   assign dst_psel    = psel_q;
   assign dst_penable = penable_q;
   assign dst_pwrite  = c_pwrite_q;
   assign dst_paddr   = c_paddr_q;
   assign dst_pwdata  = c_pwdata_q;
   assign dst_pstrb   = c_pstrb_q;
   assign dst_pprot   = c_pprot_q;

endmodule

// File: tb/tb_opendap_apb4_async_bridge.sv
// Directed bench for opendap_apb4_async_bridge: normal write/read, timeout,
// drain, src reset mid-handshake and dst reset with reissue.
`timescale 1ns/100ps

module tb_opendap_apb4_async_bridge;

   localparam int T = 64;

   logic clk_src = 1'b0;
   logic clk_dst = 1'b0;
   bit   src_run = 1'b1;
   bit   dst_run = 1'b1;
   logic rst_n_src, rst_n_dst;

   logic        src_psel, src_penable, src_pwrite;
   logic [7:0]  src_paddr;
   logic [31:0] src_pwdata;
   logic [3:0]  src_pstrb;
   logic [2:0]  src_pprot;
   logic [31:0] src_prdata;
   logic        src_pready, src_pslverr, src_timeout_flag, src_timeout_clr, src_draining;
   logic        dst_psel, dst_penable, dst_pwrite;
   logic [7:0]  dst_paddr;
   logic [31:0] dst_pwdata;
   logic [3:0]  dst_pstrb;
   logic [2:0]  dst_pprot;
   logic [31:0] dst_prdata;
   logic        dst_pready, dst_pslverr;

   // 50 MHz source, ~13 MHz destination; each can be frozen by the bench.
   always #10 if (src_run) clk_src = ~clk_src;
   always #38 if (dst_run) clk_dst = ~clk_dst;

   opendap_apb4_async_bridge #(
      .W_ADDR(8), .W_DATA(32), .N_SYNC_STAGES(2), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk_src(clk_src), .rst_n_src(rst_n_src), .clk_dst(clk_dst), .rst_n_dst(rst_n_dst),
      .src_psel(src_psel), .src_penable(src_penable), .src_pwrite(src_pwrite),
      .src_paddr(src_paddr), .src_pwdata(src_pwdata), .src_pstrb(src_pstrb), .src_pprot(src_pprot),
      .src_prdata(src_prdata), .src_pready(src_pready), .src_pslverr(src_pslverr),
      .src_timeout_flag(src_timeout_flag), .src_timeout_clr(src_timeout_clr),
      .src_draining(src_draining),
      .dst_psel(dst_psel), .dst_penable(dst_penable), .dst_pwrite(dst_pwrite),
      .dst_paddr(dst_paddr), .dst_pwdata(dst_pwdata), .dst_pstrb(dst_pstrb), .dst_pprot(dst_pprot),
      .dst_prdata(dst_prdata), .dst_pready(dst_pready), .dst_pslverr(dst_pslverr)
   );

   // dst slave model with programmable wait states and transfer log.
   logic [31:0] slv_rdata = '0;
   logic        slv_err   = 1'b0;
   int          slv_wait  = 0;
   int          wcnt      = 0;
   int          xfer_cnt  = 0;
   int          setup_cnt = 0;
   int          psel_cyc  = 0;
   logic [7:0]  last_addr;
   logic [31:0] last_wdata;
   logic [3:0]  last_strb;
   logic [2:0]  last_prot;
   logic        last_write;

   assign dst_prdata  = slv_rdata;
   assign dst_pslverr = slv_err;
   assign dst_pready  = dst_penable && (wcnt >= slv_wait);

   always @(posedge clk_dst) begin
      if (dst_psel && dst_penable && !dst_pready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (dst_psel) psel_cyc <= psel_cyc + 1;
      if (dst_psel && !dst_penable) setup_cnt <= setup_cnt + 1;
      if (dst_psel && dst_penable && dst_pready) begin
         xfer_cnt   <= xfer_cnt + 1;
         last_addr  <= dst_paddr;
         last_wdata <= dst_pwdata;
         last_strb  <= dst_pstrb;
         last_prot  <= dst_pprot;
         last_write <= dst_pwrite;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One APB access on the src port. p0 is pready in the first access cycle,
   // rise is the index of the src edge after the setup edge at which pready rose.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr,
                           output logic [31:0] rd, output logic err,
                           output logic p0, output int rise);
      @(negedge clk_src);
      src_psel = 1'b1; src_penable = 1'b0; src_pwrite = wr;
      src_paddr = addr; src_pwdata = wd; src_pstrb = st; src_pprot = pr;
      @(posedge clk_src);
      #1 src_penable = 1'b1;
      rise = 0;
      @(negedge clk_src);
      p0 = src_pready;
      while (!src_pready && rise < 200) begin
         @(negedge clk_src);
         rise++;
      end
      check("xfer_done", src_pready, 1'b1);
      rd  = src_prdata;
      err = src_pslverr;
      @(posedge clk_src);
      #1 src_psel = 1'b0; src_penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        err, p0;
      int          rise, x0, s0, c0;

      rst_n_src = 1'b0; rst_n_dst = 1'b0;
      src_psel = 1'b0; src_penable = 1'b0; src_pwrite = 1'b0;
      src_paddr = '0; src_pwdata = '0; src_pstrb = '0; src_pprot = '0;
      src_timeout_clr = 1'b0;
      #150;
      // Reset values.
      check("rst_pready",   src_pready, 1'b1);
      check("rst_pslverr",  src_pslverr, 1'b0);
      check("rst_prdata",   src_prdata, 32'h0);
      check("rst_flag",     src_timeout_flag, 1'b0);
      check("rst_draining", src_draining, 1'b0);
      check("rst_dst_psel", dst_psel, 1'b0);
      check("rst_dst_pen",  dst_penable, 1'b0);
      rst_n_dst = 1'b1;
      @(negedge clk_src) rst_n_src = 1'b1;
      repeat (4) @(negedge clk_src);

      // Write: one dst transfer with identical fields.
      x0 = xfer_cnt;
      apb_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 3'b010, rd, err, p0, rise);
      check("wr_p0", p0, 1'b0);
      check("wr_err", err, 1'b0);
      check("wr_count", xfer_cnt - x0, 1);
      check("wr_addr", last_addr, 8'h10);
      check("wr_wdata", last_wdata, 32'hDEADBEEF);
      check("wr_strb", last_strb, 4'hF);
      check("wr_prot", last_prot, 3'b010);
      check("wr_write", last_write, 1'b1);
      check("idle_pready", src_pready, 1'b1);

      // Read with 3 wait states and slave error.
      slv_wait = 3; slv_rdata = 32'h12345678; slv_err = 1'b1;
      x0 = xfer_cnt; c0 = psel_cyc;
      apb_xfer(1'b0, 8'h24, 32'h0, 4'h0, 3'b000, rd, err, p0, rise);
      check("rd_data", rd, 32'h12345678);
      check("rd_err", err, 1'b1);
      check("rd_count", xfer_cnt - x0, 1);
      check("rd_psel_cycles", psel_cyc - c0, 5);
      check("rd_write", last_write, 1'b0);

      // Timeout with clk_dst stopped.
      slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0;
      dst_run = 1'b0;
      x0 = xfer_cnt;
      apb_xfer(1'b1, 8'h20, 32'hCAFEF00D, 4'h3, 3'b001, rd, err, p0, rise);
      check("to_rise_edge", rise, T);
      check("to_err", err, 1'b1);
      check("to_data", rd, 32'h0);
      check("to_flag", src_timeout_flag, 1'b1);
      check("to_draining", src_draining, 1'b1);

      // Drain: new access gets an immediate error and no dst access.
      apb_xfer(1'b0, 8'h30, 32'h0, 4'h0, 3'b000, rd, err, p0, rise);
      check("drain_p0", p0, 1'b1);
      check("drain_err", err, 1'b1);
      check("drain_data", rd, 32'h0);
      check("drain_still", src_draining, 1'b1);
      check("drain_no_xfer", xfer_cnt - x0, 0);
      dst_run = 1'b1;
      for (int i = 0; i < 300 && src_draining; i++) @(negedge clk_src);
      check("drain_done", src_draining, 1'b0);
      check("drain_count", xfer_cnt - x0, 1);
      check("drain_addr", last_addr, 8'h20);
      check("drain_wdata", last_wdata, 32'hCAFEF00D);
      check("drain_strb", last_strb, 4'h3);
      check("drain_prot", last_prot, 3'b001);
      slv_rdata = 32'h0BADCAFE;
      apb_xfer(1'b0, 8'h31, 32'h0, 4'h0, 3'b000, rd, err, p0, rise);
      check("post_drain_data", rd, 32'h0BADCAFE);
      check("post_drain_err", err, 1'b0);
      check("post_drain_addr", last_addr, 8'h31);
      check("flag_sticky", src_timeout_flag, 1'b1);
      @(negedge clk_src) src_timeout_clr = 1'b1;
      @(negedge clk_src) src_timeout_clr = 1'b0;
      check("flag_clr", src_timeout_flag, 1'b0);

      // src reset while waiting for ack to fall.
      slv_wait = 8;
      x0 = xfer_cnt; s0 = setup_cnt;
      @(negedge clk_src);
      src_psel = 1'b1; src_penable = 1'b0; src_pwrite = 1'b1;
      src_paddr = 8'h50; src_pwdata = 32'h11112222; src_pstrb = 4'hF; src_pprot = 3'b000;
      @(posedge clk_src);
      #1 src_penable = 1'b1;
      for (int i = 0; i < 50 && !dst_psel; i++) @(negedge clk_dst);
      check("sr_launch", dst_psel, 1'b1);
      repeat (6) @(posedge clk_src);
      #1 check("sr_pending", src_pready, 1'b0);
      rst_n_src = 1'b0; src_psel = 1'b0; src_penable = 1'b0;
      #1;
      check("sr_pready", src_pready, 1'b1);
      check("sr_pslverr", src_pslverr, 1'b0);
      check("sr_prdata", src_prdata, 32'h0);
      @(negedge clk_src) rst_n_src = 1'b1;
      for (int i = 0; i < 50 && dst_psel; i++) @(negedge clk_dst);
      repeat (30) @(negedge clk_src);
      check("sr_count", xfer_cnt - x0, 1);
      check("sr_setups", setup_cnt - s0, 1);
      slv_wait = 1;
      apb_xfer(1'b1, 8'h60, 32'hA5A55A5A, 4'h5, 3'b100, rd, err, p0, rise);
      check("sr_next_err", err, 1'b0);
      check("sr_next_count", xfer_cnt - x0, 2);
      check("sr_next_addr", last_addr, 8'h60);
      check("sr_next_wdata", last_wdata, 32'hA5A55A5A);
      check("sr_next_strb", last_strb, 4'h5);

      // dst reset with req held high (src clock frozen): transfer is reissued.
      slv_wait = 4; slv_rdata = 32'h600DF00D; slv_err = 1'b0;
      x0 = xfer_cnt; s0 = setup_cnt;
      @(negedge clk_src);
      src_psel = 1'b1; src_penable = 1'b0; src_pwrite = 1'b0;
      src_paddr = 8'h70; src_pwdata = 32'h0; src_pstrb = 4'h0; src_pprot = 3'b000;
      @(posedge clk_src);
      #1 src_penable = 1'b1;
      src_run = 1'b0;
      for (int i = 0; i < 20 && !dst_psel; i++) @(negedge clk_dst);
      check("dr_launch", dst_psel, 1'b1);
      @(negedge clk_dst);
      check("dr_penable", dst_penable, 1'b1);
      #5 rst_n_dst = 1'b0;
      #1;
      check("dr_rst_psel", dst_psel, 1'b0);
      check("dr_rst_pen", dst_penable, 1'b0);
      #10 rst_n_dst = 1'b1;
      for (int i = 0; i < 40 && xfer_cnt == x0; i++) @(negedge clk_dst);
      src_run = 1'b1;
      rise = 0;
      @(negedge clk_src);
      while (!src_pready && rise < 200) begin
         @(negedge clk_src);
         rise++;
      end
      check("dr_done", src_pready, 1'b1);
      check("dr_data", src_prdata, 32'h600DF00D);
      check("dr_err", src_pslverr, 1'b0);
      @(posedge clk_src);
      #1 src_psel = 1'b0; src_penable = 1'b0;
      check("dr_setups", setup_cnt - s0, 2);
      check("dr_count", xfer_cnt - x0, 1);
      check("dr_addr", last_addr, 8'h70);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/opendap_apb4_async_bridge.md
# opendap_apb4_async_bridge

Parametrised APB4-to-APB4 asynchronous bridge on the bottom side of the Mem-AP, crossing from the transport clock domain (clk_src) into the target bus domain (clk_dst). It carries PSTRB/PPROT, uses a level req/ack four-phase handshake with N-stage 1-bit synchronisers, and adds a src-side timeout. The timeout returns PSLVERR when the dst domain is unclocked or held in reset, so the debug host never hangs. After a timeout, the block drains the abandoned request safely before it accepts new traffic.

## Interface
- W_ADDR, 8, address width
- W_DATA, 32, data width; must be a multiple of 8
- N_SYNC_STAGES, 2, flops per req/ack synchroniser (opendap_sync_1bit)
- TIMEOUT_CYCLES, 1024, clk_src cycles from launch to error completion; 0 disables the timeout
- clk_src  in  1  src clock
- rst_n_src  in  1  src reset, asynchronous, active-low (externally synchronised deassertion)
- clk_dst  in  1  dst clock
- rst_n_dst  in  1  dst reset, asynchronous, active-low
- src_psel, src_penable, src_pwrite  in  1  APB4 slave control
- src_paddr  in  W_ADDR; src_pwdata  in  W_DATA; src_pstrb  in  W_DATA/8; src_pprot  in  3
- src_prdata  out  W_DATA; src_pready  out  1; src_pslverr  out  1
- src_timeout_flag  out  1  sticky; set on any timeout
- src_timeout_clr  in  1  clears src_timeout_flag (set wins if both occur in the same cycle)
- src_draining  out  1  high while the src FSM is in DRAIN_REQ or DRAIN_ACK
- dst_psel, dst_penable, dst_pwrite  out  1; dst_paddr  out  W_ADDR; dst_pwdata  out  W_DATA; dst_pstrb  out  W_DATA/8; dst_pprot  out  3
- dst_prdata  in  W_DATA; dst_pready  in  1; dst_pslverr  in  1

## Operation
- Launch register L (src: paddr, pwdata, pstrb, pprot, pwrite) is non-reset. It loads only on acceptance in IDLE and is frozen in every other state.
- Response register R (dst: prdata, pslverr) is non-reset. It loads on dst_penable && dst_pready.
- Capture registers are loaded cross-domain only while the source side is guaranteed stable by the handshake.
- src FSM states and transitions:
  - IDLE: on src_psel && !src_penable, load L, req<=1, pready<=0, cnt<=0, go to REQ.
  - REQ: on ack=1, req<=0 and go to ACKW.
  - ACKW: on ack=0, pready<=1, {prdata,pslverr}<=R, go to IDLE.
  - Timeout in REQ or ACKW (cnt==TIMEOUT_CYCLES-1 and the normal exit condition is false): pready<=1, pslverr<=1, prdata<=0, flag<=1.
    - From REQ, go to DRAIN_REQ with req held at 1.
    - From ACKW, go to DRAIN_ACK.
  - DRAIN_REQ: on ack=1, req<=0 and go to DRAIN_ACK.
  - DRAIN_ACK: on ack=0, go to IDLE. The response is discarded.
  - Any setup phase seen during a DRAIN state is not launched. Its access phase completes with pready=1, pslverr=1, prdata=0, and L is untouched.
- dst side:
  - ack rises on synchronised req=1.
  - ack falls when req=0 && !dst_psel.
  - On req && !ack: load the dst capture register from L and set dst_psel=1.
  - Next cycle: dst_penable=1.
  - When dst_penable && dst_pready: dst_psel and dst_penable go to 0.
- Simultaneous events: if the normal exit condition and the timeout coincide, the normal exit wins.
- Reset values:
  - src side: src_pready=1, src_pslverr=0, src_prdata=0, flag=0, req=0, FSM=IDLE.
  - dst side: dst_psel=0, dst_penable=0, ack=0.
  - dst_paddr, dst_pwdata, dst_pstrb, dst_pprot and dst_pwrite come from the non-reset capture register and are undefined until the first transfer.
- Reset of src mid-transfer: req drops. If the dst transfer has already started, it completes and its result is lost. The handshake recovers without a spurious dst access.
- Reset of dst mid-transfer: ack clears. If req is still high, the transfer is reissued; otherwise the src side times out.

## Timing
- Setup phase at edge 0 gives src_pready=0 from edge 1 (the first access cycle).
- dst_psel rises N_SYNC_STAGES+1 clk_dst edges after req rises.
- dst access is at least 2 dst cycles plus slave wait states.
- Total latency is about 2·(N_SYNC_STAGES+1) dst edges plus 2·(N_SYNC_STAGES+1) src edges plus the dst transfer time.
- Timeout: with TIMEOUT_CYCLES=T, an error access phase ends T src cycles after the setup edge.
- Counter width is clog2(T+1). It saturates at T, is unused when T=0, and never wraps.
- Drain-mode error response: zero wait states, so src_pready=1 in the first access cycle.
- src_pready remains 1 in IDLE. src_prdata and src_pslverr hold their last values until the next completion.

## Test plan
- Write: paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF with clk_src 50 MHz and clk_dst 13 MHz -> exactly one dst transfer with identical fields; src completes with pslverr=0.
- Read: dst slave returns 0x12345678 after 3 wait states, pslverr=1 -> src_prdata=0x12345678, src_pslverr=1; dst_psel was high for exactly 5 dst cycles.
- Timeout: T=64 with clk_dst stopped -> src_pready=1, pslverr=1, prdata=0 at the 64th cycle; flag=1; src_draining=1.
- Drain: while draining, issue a read -> immediate error, no dst access. Restart clk_dst -> exactly one dst transfer of the original request, then src_draining=0, and the next transfer completes normally.
- Reset of src mid-ACKW -> no extra dst transfer; the following write completes correctly.
- Reset of dst while req is high -> the transfer is reissued and src completes without error when T=0.
